uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter_rr.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e : frame FSM encoding (idle, send, wait, done)
//   bytes_of    : bytes per frame word
//   cnt_width   : counter width for a count of n values (never below 1)
package uart_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_BYTES      = DEF_DATA_WIDTH / 8;

  function automatic int unsigned bytes_of(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus between frame sources, the arbiter and the shared byte transmitter.
//   req/req_data          : per-requester level request and flattened words
//   grant/frame_done/busy : ownership, end-of-frame pulse, activity flag
//   tx_byte/tx_send_en    : byte and start pulse towards the transmitter
//   tx_done               : completion pulse from the transmitter
//   timeout_err           : watchdog abort pulse
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            frame_done;
  logic                          busy;
  logic [7:0]                    tx_byte;
  logic                          tx_send_en;
  logic                          tx_done;
  logic                          timeout_err;

  modport master (
    input  req, req_data, tx_done,
    output grant, frame_done, busy, tx_byte, tx_send_en, timeout_err
  );

  modport slave (
    output req, req_data, tx_done,
    input  grant, frame_done, busy, tx_byte, tx_send_en, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first asserted request searching upward
// from i_ptr+1 with wrap-around.
//   i_req   : request vector
//   i_ptr   : index of the last served requester
//   o_grant : one-hot winner (0 when nothing requested)
//   o_idx   : winner index
//   o_valid : any request present
module uart_rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]               i_req,
  input  logic [cnt_width(NUM_REQ)-1:0]    i_ptr,
  output logic [NUM_REQ-1:0]               o_grant,
  output logic [cnt_width(NUM_REQ)-1:0]    o_idx,
  output logic                             o_valid
);
  localparam int unsigned IW = cnt_width(NUM_REQ);

  int unsigned w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_j = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_valid && |(i_req & (NUM_REQ'(1) << w_j))) begin
        o_valid = 1'b1;
        o_grant = NUM_REQ'(1) << w_j;
        o_idx   = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-level UART transmitter among NUM_REQ frame sources.
// The round-robin winner's word is captured at grant, then sent one byte per
// tx_send_en pulse, each paced by tx_done.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   arb_bus      : uart_tx_arbiter_if.master (requests, grant, byte stream)
// Optional build macro UART_ARB_TIMEOUT_EN adds a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles that aborts the frame and pulses timeout_err.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MSB_FIRST      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic               i_clk,
  input logic               i_rst,
  uart_tx_arbiter_if.master arb_bus
);
  localparam int unsigned BYTES = bytes_of(DATA_WIDTH);
  localparam int unsigned BW    = cnt_width(BYTES);
  localparam int unsigned IW    = cnt_width(NUM_REQ);

  arb_state_e              r_state;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           r_owner;
  logic [BW-1:0]           r_byte_cnt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      r_frame_done;
  logic                    r_busy;
  logic [7:0]              r_tx_byte;
  logic                    r_tx_send_en;

  logic [NUM_REQ-1:0]      w_pick_grant;
  logic [IW-1:0]           w_pick_idx;
  logic                    w_pick_valid;
  logic [DATA_WIDTH-1:0]   w_word;
  logic [DATA_WIDTH-1:0]   w_shift_nxt;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req   (arb_bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_word      = arb_bus.req_data[w_pick_idx * DATA_WIDTH +: DATA_WIDTH];
  assign w_shift_nxt = (MSB_FIRST != 0) ? (r_shift << 8) : (r_shift >> 8);

  // Byte that goes on the wire next, taken from the send end of the register.
  function automatic logic [7:0] lead_byte(input logic [DATA_WIDTH-1:0] v);
    if (MSB_FIRST != 0) return v[DATA_WIDTH-1 -: 8];
    return v[7:0];
  endfunction

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
  logic [TW-1:0] r_wd;
  logic          r_timeout_err;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_ptr        <= IW'(NUM_REQ - 1);
      r_owner      <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_grant      <= '0;
      r_frame_done <= '0;
      r_busy       <= 1'b0;
      r_tx_byte    <= '0;
      r_tx_send_en <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      r_tx_send_en <= 1'b0;
      r_frame_done <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (w_pick_valid) begin
            r_shift      <= w_word;
            r_grant      <= w_pick_grant;
            r_owner      <= w_pick_idx;
            r_byte_cnt   <= '0;
            r_tx_byte    <= lead_byte(w_word);
            r_tx_send_en <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= StSend;
          end
        end
        StSend: begin
`ifdef UART_ARB_TIMEOUT_EN
          r_wd <= '0;
`endif
          r_state <= StWait;
        end
        StWait: begin
          if (arb_bus.tx_done) begin
            if (r_byte_cnt == BW'(BYTES - 1)) begin
              r_frame_done <= r_grant;
              r_state      <= StDone;
            end else begin
              r_shift      <= w_shift_nxt;
              r_byte_cnt   <= r_byte_cnt + 1'b1;
              r_tx_byte    <= lead_byte(w_shift_nxt);
              r_tx_send_en <= 1'b1;
              r_state      <= StSend;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (r_wd == TW'(TIMEOUT_CYCLES - 1)) begin
            // Transmitter stalled: drop the frame without frame_done.
            r_timeout_err <= 1'b1;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_tx_byte     <= '0;
            r_ptr         <= r_owner;
            r_state       <= StIdle;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end
        StDone: begin
          r_grant   <= '0;
          r_busy    <= 1'b0;
          r_tx_byte <= '0;
          r_ptr     <= r_owner;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign arb_bus.grant      = r_grant;
  assign arb_bus.frame_done = r_frame_done;
  assign arb_bus.busy       = r_busy;
  assign arb_bus.tx_byte    = r_tx_byte;
  assign arb_bus.tx_send_en = r_tx_send_en;

`ifdef UART_ARB_TIMEOUT_EN
  assign arb_bus.timeout_err = r_timeout_err;
`else
  // Keeps the watchdog parameter referenced in builds without the watchdog.
  logic w_unused_timeout;
  assign w_unused_timeout    = ^TIMEOUT_CYCLES;
  assign arb_bus.timeout_err = 1'b0;
`endif

endmodule
